// File: rtl/depipe_pkg.sv
// -----------------------------------------------------------------------------
// depipe_pkg
//  Shared types for the Decode->Execute elastic stage.
//  - ctrl_t       : the five single-bit control flags carried D->E
//  - de_payload_t : full decoded payload at the default field widths
//  - state_t      : occupancy state of the 2-entry skid buffer
//  - occ_of()     : entry count held in a given state
// -----------------------------------------------------------------------------
package depipe_pkg;

    localparam int DE_N   = 32;
    localparam int DE_M   = 4;
    localparam int DE_L   = 3;
    localparam int DE_OPW = 5;

    typedef struct packed {
        logic regw;
        logic memw;
        logic regmem;
        logic aluope;
        logic branch;
    } ctrl_t;

    typedef struct packed {
        ctrl_t              ctrl;
        logic [DE_OPW-1:0]  op_code;
        logic [DE_L-1:0]    alu_ctrl;
        logic [DE_M-1:0]    reg_scr;
        logic [DE_M-1:0]    reg_a_idx;
        logic [DE_M-1:0]    reg_b_idx;
        logic [DE_N-1:0]    reg_a;
        logic [DE_N-1:0]    reg_b;
        logic [DE_N-1:0]    inm;
    } de_payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    function automatic logic [1:0] occ_of(input state_t s);
        case (s)
            ONE:     return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_skid.sv
// -----------------------------------------------------------------------------
// pipe_skid
//  Generic 2-entry skid buffer on a flat W-bit payload. The main register
//  drives the output; the skid register absorbs the one extra beat that can
//  arrive while the consumer stalls. ready_o, valid_o and occ_o are flops
//  computed from the next state, so ready_o has no combinational path from
//  ready_i. flush_i empties the buffer and drops any beat offered that cycle.
//  Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush_i             discard contents and the incoming beat
//   valid_i / ready_o   upstream handshake, data_i payload
//   valid_o / ready_i   downstream handshake, data_o payload
//   occ_o               entries held (0..2)
// -----------------------------------------------------------------------------
module pipe_skid
    import depipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o,
    output logic [1:0]   occ_o
);

    state_t       state_q, state_d;
    logic         ready_q, valid_q;
    logic [1:0]   occ_q;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_fire, out_fire;

    assign in_fire  = valid_i & ready_q;
    assign out_fire = valid_q & ready_i;

    // State register; status outputs are registered from the next state.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            occ_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != FULL);
            valid_q <= (state_d != EMPTY);
            occ_q   <= occ_of(state_d);
        end
    end

    // Next-state logic; flush overrides every handshake.
    // NOTE: each always_comb output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (in_fire) state_d = ONE;
                ONE: begin
                    if (in_fire && !out_fire)      state_d = FULL;
                    else if (!in_fire && out_fire) state_d = EMPTY;
                end
                FULL:  if (out_fire) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Payload steering. A flushed cycle loads nothing, so the dropped beat
    // can never surface later.
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (!flush_i) begin
            case (state_q)
                EMPTY: if (in_fire) main_d = data_i;
                ONE: begin
                    if (in_fire) begin
                        if (out_fire) main_d = data_i;
                        else          skid_d = data_i;
                    end
                end
                FULL:  if (out_fire) main_d = skid_q;
                default: ;
            endcase
        end
    end

    // NOTE: the payload registers are reset even though they are datapath:
    // the main register is visible on the outputs during bubbles when data
    // clearing is disabled, and no X may reach the outputs after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign ready_o = ready_q;
    assign valid_o = valid_q;
    assign occ_o   = occ_q;
    assign data_o  = main_q;

endmodule

// File: rtl/depipe_elastic.sv
// -----------------------------------------------------------------------------
// depipe_elastic
//  Decode->Execute pipeline register with valid/ready handshake, 2-entry skid
//  buffer and flush. Full throughput with no combinational ready path.
//  When valid_E is low the stage presents a bubble: control, op_code and
//  ALU control read 0; data/index fields read 0 only when CLEAR_DATA=1.
//  Ports:
//   clk, rst                    clock, synchronous active-high reset
//   flush_E                     kill stage contents and incoming instruction
//   valid_D / ready_D           decode handshake, *_D payload fields
//   valid_E / ready_E           execute handshake, *_E payload fields
//   occ                         entries held (0..2)
// -----------------------------------------------------------------------------
module depipe_elastic
    import depipe_pkg::*;
#(
    parameter int N          = 32,
    parameter int M          = 4,
    parameter int L          = 3,
    parameter int OPW        = 5,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush_E,
    input  logic           valid_D,
    output logic           ready_D,
    input  logic           regw_D,
    input  logic           memw_D,
    input  logic           regmem_D,
    input  logic           ALUope_D,
    input  logic           branch_D,
    input  logic [OPW-1:0] op_code_D,
    input  logic [L-1:0]   ALUctrl_D,
    input  logic [M-1:0]   regScr_D,
    input  logic [M-1:0]   regAD,
    input  logic [M-1:0]   regBD,
    input  logic [N-1:0]   regA_D,
    input  logic [N-1:0]   regB_D,
    input  logic [N-1:0]   inm_D,
    output logic           valid_E,
    input  logic           ready_E,
    output logic           regw_E,
    output logic           memw_E,
    output logic           regmem_E,
    output logic           ALUope_E,
    output logic           branch_E,
    output logic [OPW-1:0] op_code_E,
    output logic [L-1:0]   ALUctrl_E,
    output logic [M-1:0]   regScr_E,
    output logic [M-1:0]   regAE,
    output logic [M-1:0]   regBE,
    output logic [N-1:0]   regA_E,
    output logic [N-1:0]   regB_E,
    output logic [N-1:0]   inm_E,
    output logic [1:0]     occ
);

    // Payload split: control part (always masked in bubbles) then data part.
    localparam int CW = $bits(ctrl_t) + OPW + L;
    localparam int DW = 3 * M + 3 * N;
    localparam int W  = CW + DW;

    ctrl_t         ctrl_in, ctrl_e;
    logic [W-1:0]  pay_in, pay_out;
    logic [CW-1:0] ctrl_out;
    logic [DW-1:0] data_out;

    assign ctrl_in = '{regw: regw_D, memw: memw_D, regmem: regmem_D,
                       aluope: ALUope_D, branch: branch_D};

    assign pay_in = {ctrl_in, op_code_D, ALUctrl_D,
                     regScr_D, regAD, regBD, regA_D, regB_D, inm_D};

    pipe_skid #(.W(W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_E),
        .valid_i (valid_D),
        .ready_o (ready_D),
        .data_i  (pay_in),
        .valid_o (valid_E),
        .ready_i (ready_E),
        .data_o  (pay_out),
        .occ_o   (occ)
    );

    assign ctrl_out = valid_E ? pay_out[W-1 -: CW] : '0;
    assign data_out = (valid_E || !CLEAR_DATA) ? pay_out[DW-1:0] : '0;

    assign {ctrl_e, op_code_E, ALUctrl_E} = ctrl_out;
    assign regw_E   = ctrl_e.regw;
    assign memw_E   = ctrl_e.memw;
    assign regmem_E = ctrl_e.regmem;
    assign ALUope_E = ctrl_e.aluope;
    assign branch_E = ctrl_e.branch;

    assign {regScr_E, regAE, regBE, regA_E, regB_E, inm_E} = data_out;

endmodule

// File: tb/tb_depipe_elastic.sv
// -----------------------------------------------------------------------------
// tb_depipe_elastic
//  Drives two instances in lockstep (CLEAR_DATA=1 and CLEAR_DATA=0) and
//  compares them against a queue-based model of the stage: a FIFO of at most
//  two entries whose head is the execute payload.
// -----------------------------------------------------------------------------
module tb_depipe_elastic;

    typedef struct packed {
        logic        regw, memw, regmem, aluope, branch;
        logic [4:0]  op;
        logic [2:0]  alu;
        logic [3:0]  rs, ra, rb;
        logic [31:0] a, b, imm;
    } pl_t;

    typedef struct {
        logic        rst, flush, vld, rdy;
        logic [31:0] imm;
        logic        e_valid, e_ready;
        logic [1:0]  e_occ;
        logic [31:0] e_imm;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush_E, valid_D, ready_E;
    pl_t  din;

    logic        ready_D, valid_E, ready_D0, valid_E0;
    logic        regw_E, memw_E, regmem_E, ALUope_E, branch_E;
    logic [4:0]  op_code_E;
    logic [2:0]  ALUctrl_E;
    logic [3:0]  regScr_E, regAE, regBE;
    logic [31:0] regA_E, regB_E, inm_E;
    logic [1:0]  occ, occ0;
    logic        regw_E0, memw_E0, regmem_E0, ALUope_E0, branch_E0;
    logic [4:0]  op_code_E0;
    logic [2:0]  ALUctrl_E0;
    logic [3:0]  regScr_E0, regAE0, regBE0;
    logic [31:0] regA_E0, regB_E0, inm_E0;
    pl_t         dout, dout0;

    assign dout  = {regw_E, memw_E, regmem_E, ALUope_E, branch_E, op_code_E, ALUctrl_E,
                    regScr_E, regAE, regBE, regA_E, regB_E, inm_E};
    assign dout0 = {regw_E0, memw_E0, regmem_E0, ALUope_E0, branch_E0, op_code_E0, ALUctrl_E0,
                    regScr_E0, regAE0, regBE0, regA_E0, regB_E0, inm_E0};

    depipe_elastic #(.CLEAR_DATA(1'b1)) dut (
        .clk(clk), .rst(rst), .flush_E(flush_E), .valid_D(valid_D), .ready_D(ready_D),
        .regw_D(din.regw), .memw_D(din.memw), .regmem_D(din.regmem), .ALUope_D(din.aluope),
        .branch_D(din.branch), .op_code_D(din.op), .ALUctrl_D(din.alu),
        .regScr_D(din.rs), .regAD(din.ra), .regBD(din.rb),
        .regA_D(din.a), .regB_D(din.b), .inm_D(din.imm),
        .valid_E(valid_E), .ready_E(ready_E),
        .regw_E(regw_E), .memw_E(memw_E), .regmem_E(regmem_E), .ALUope_E(ALUope_E),
        .branch_E(branch_E), .op_code_E(op_code_E), .ALUctrl_E(ALUctrl_E),
        .regScr_E(regScr_E), .regAE(regAE), .regBE(regBE),
        .regA_E(regA_E), .regB_E(regB_E), .inm_E(inm_E), .occ(occ)
    );

    depipe_elastic #(.CLEAR_DATA(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush_E(flush_E), .valid_D(valid_D), .ready_D(ready_D0),
        .regw_D(din.regw), .memw_D(din.memw), .regmem_D(din.regmem), .ALUope_D(din.aluope),
        .branch_D(din.branch), .op_code_D(din.op), .ALUctrl_D(din.alu),
        .regScr_D(din.rs), .regAD(din.ra), .regBD(din.rb),
        .regA_D(din.a), .regB_D(din.b), .inm_D(din.imm),
        .valid_E(valid_E0), .ready_E(ready_E),
        .regw_E(regw_E0), .memw_E(memw_E0), .regmem_E(regmem_E0), .ALUope_E(ALUope_E0),
        .branch_E(branch_E0), .op_code_E(op_code_E0), .ALUctrl_E(ALUctrl_E0),
        .regScr_E(regScr_E0), .regAE(regAE0), .regBE(regBE0),
        .regA_E(regA_E0), .regB_E(regB_E0), .inm_E(inm_E0), .occ(occ0)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: FIFO contents and the most recent head payload
    // (what a CLEAR_DATA=0 stage still shows during a bubble).
    pl_t  q[$];
    pl_t  last_head = '0;
    logic known = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic pl_t rand_pl();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return pl_t'(r[120:0]);
    endfunction

    function automatic pl_t imm_pl(input logic [31:0] v);
        pl_t p;
        p = '0;
        p.imm = v;
        return p;
    endfunction

    task automatic check_model();
        pl_t e1, e0;
        logic mv;
        mv = (q.size() != 0);
        e1 = mv ? q[0] : '0;
        e0 = last_head;
        if (!mv) begin
            {e0.regw, e0.memw, e0.regmem, e0.aluope, e0.branch} = '0;
            e0.op  = '0;
            e0.alu = '0;
        end
        check("valid_E",  valid_E,  mv);
        check("ready_D",  ready_D,  q.size() < 2);
        check("occ",      occ,      q.size());
        check("payload",  dout,     e1);
        check("valid_E0", valid_E0, mv);
        check("ready_D0", ready_D0, q.size() < 2);
        check("occ0",     occ0,     q.size());
        check("payload0", dout0,    e0);
    endtask

    // One clock: drive inputs, confirm ready_D is independent of the freshly
    // driven ready_E, clock, advance the model, compare everything.
    task automatic cyc(input logic r_st, input logic fl, input logic v,
                       input logic rd, input pl_t d);
        logic m_ready, m_valid, in_f, out_f;
        rst = r_st; flush_E = fl; valid_D = v; ready_E = rd; din = d;
        #1;
        m_ready = (q.size() < 2);
        m_valid = (q.size() != 0);
        if (known) check("ready_D_pre", ready_D, m_ready);
        @(posedge clk);
        if (r_st) begin
            q.delete();
            last_head = '0;
            known = 1'b1;
        end else begin
            in_f  = v & m_ready;
            out_f = m_valid & rd;
            if (fl) begin
                q.delete();
            end else begin
                if (out_f) void'(q.pop_front());
                if (in_f)  q.push_back(d);
            end
            if (q.size() != 0) last_head = q[0];
        end
        #1;
        if (known) check_model();
    endtask

    vec_t tbl[16];

    function automatic vec_t mk(input logic r, f, v, rd, input logic [31:0] im,
                                input logic ev, er, input logic [1:0] eo,
                                input logic [31:0] ei);
        vec_t x;
        x.rst = r; x.flush = f; x.vld = v; x.rdy = rd; x.imm = im;
        x.e_valid = ev; x.e_ready = er; x.e_occ = eo; x.e_imm = ei;
        return x;
    endfunction

    initial begin
        pl_t p;

        // Reset, 8-beat stream, drain, then stall sequence 10/11/12.
        tbl[0] = mk(1, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int k = 1; k <= 8; k++)
            tbl[k] = mk(0, 0, 1, 1, k, 1, 1, 1, k);
        tbl[9]  = mk(0, 0, 0, 1, 0,  0, 1, 0, 0);
        tbl[10] = mk(0, 0, 1, 0, 10, 1, 1, 1, 10);
        tbl[11] = mk(0, 0, 1, 0, 11, 1, 0, 2, 10);
        tbl[12] = mk(0, 0, 1, 0, 12, 1, 0, 2, 10);
        tbl[13] = mk(0, 0, 1, 1, 12, 1, 1, 1, 11);
        tbl[14] = mk(0, 0, 1, 1, 12, 1, 1, 1, 12);
        tbl[15] = mk(0, 0, 0, 1, 0,  0, 1, 0, 0);

        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].rst, tbl[i].flush, tbl[i].vld, tbl[i].rdy, imm_pl(tbl[i].imm));
            check($sformatf("tbl%0d_valid", i), valid_E, tbl[i].e_valid);
            check($sformatf("tbl%0d_ready", i), ready_D, tbl[i].e_ready);
            check($sformatf("tbl%0d_occ", i),   occ,     tbl[i].e_occ);
            check($sformatf("tbl%0d_imm", i),   inm_E,   tbl[i].e_imm);
        end

        // Flush while FULL drops both entries and the offered instruction.
        cyc(0, 0, 1, 0, imm_pl(1));
        cyc(0, 0, 1, 0, imm_pl(2));
        check("flush_pre_occ", occ, 2'd2);
        p = imm_pl(99);
        p.regw = 1'b1;
        cyc(0, 1, 1, 0, p);
        check("flush_valid", valid_E, 1'b0);
        check("flush_regw",  regw_E,  1'b0);
        check("flush_occ",   occ,     2'd0);
        check("flush_ready", ready_D, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, '0);
            check("flush_no_ghost", valid_E, 1'b0);
        end

        // Reset and flush together, then flush alone on EMPTY.
        cyc(0, 0, 1, 0, imm_pl(5));
        cyc(1, 1, 1, 0, imm_pl(6));
        check("rstflush_valid", valid_E, 1'b0);
        check("rstflush_occ",   occ,     2'd0);
        check("rstflush_ready", ready_D, 1'b1);
        check("rstflush_pay",   dout0,   '0);
        cyc(0, 1, 0, 1, '0);
        check("flush_empty_occ", occ, 2'd0);
        cyc(0, 0, 1, 1, imm_pl(7));
        check("post_flush_imm", inm_E, 32'd7);

        // Bubble masking with and without data clearing.
        p = rand_pl();
        p.op   = 5'h1F;
        p.memw = 1'b1;
        p.a    = 32'hDEADBEEF;
        cyc(0, 0, 1, 1, p);
        check("bub_load_op", op_code_E, 5'h1F);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, rand_pl());
            check("bub_op",    op_code_E,  5'h00);
            check("bub_memw",  memw_E,     1'b0);
            check("bub_op0",   op_code_E0, 5'h00);
            check("bub_memw0", memw_E0,    1'b0);
            check("bub_regA",  regA_E,     32'h0);
            check("bub_regA0", regA_E0,    32'hDEADBEEF);
        end

        // Randomized traffic against the FIFO model.
        for (int i = 0; i < 10000; i++) begin
            cyc(($urandom_range(0, 511) == 0),
                ($urandom_range(0, 31) == 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 2) != 0),
                rand_pl());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
